// File: rtl/jtpopeye_scan2x.sv
// jtpopeye_scan2x -- line doubler for the 15.7 kHz game video.
//
// Each input line (paced by pxl_cen) is written into one half of a
// ping-pong line buffer while the previously completed line is replayed
// twice from the other half at pxl2_cen, giving 31.5 kHz video.
//
// Ports
//   clk              system clock (20 MHz)
//   rst_n            asynchronous reset, active low
//   pxl_cen          input pixel enable (5.04 MHz)
//   pxl2_cen         output pixel enable (10.08 MHz)
//   red/green/blue   input colour, 3:3:2
//   HB/VB/HS/VS      input blanking and sync, active high
//   red_2x/green_2x/blue_2x  doubled colour
//   HB_2x/VB_2x/HS_2x/VS_2x  doubled blanking and sync
//
// Build option
//   JTPOPEYE_SCANLINES_EN  when defined, the second replay of every line is
//                          dimmed (each colour component shifted right by 1).

module jtpopeye_scan2x #(
    parameter int HLEN   = 320,
    parameter int HS_LEN = 24,
    parameter int AW     = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       pxl2_cen,
    input  logic [2:0] red,
    input  logic [2:0] green,
    input  logic [1:0] blue,
    input  logic       HB,
    input  logic       VB,
    input  logic       HS,
    input  logic       VS,
    output logic [2:0] red_2x,
    output logic [2:0] green_2x,
    output logic [1:0] blue_2x,
    output logic       HB_2x,
    output logic       VB_2x,
    output logic       HS_2x,
    output logic       VS_2x
);

    localparam logic [AW-1:0] LAST   = AW'(HLEN - 1);
    localparam logic [AW-1:0] HS_END = AW'(HS_LEN);

    // Both banks live in one array; the top address bit selects the bank.
    logic [8:0] mem [0:(1 << (AW + 1)) - 1];

    logic          hs_l_q,   hs_l_d;
    logic          vs_l_q,   vs_l_d;
    logic          vb_l_q,   vb_l_d;
    logic          bank_q,   bank_d;
    logic          valid_q,  valid_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;

    logic [2:0]    red_q,   red_d;
    logic [2:0]    green_q, green_d;
    logic [1:0]    blue_q,  blue_d;
    logic          hb_q,    hb_d;
    logic          vb_q,    vb_d;
    logic          hs_q,    hs_d;
    logic          vs_q,    vs_d;

    logic          hs_edge;
    logic [8:0]    rd_word;
    logic [2:0]    col_r;
    logic [2:0]    col_g;
    logic [1:0]    col_b;

    assign hs_edge = pxl_cen & HS & ~hs_l_q;
    // The replayed line is always the one completed last.
    assign rd_word = mem[{~bank_q, rd_cnt_q}];

    // ---------------- write side ----------------
    always_comb begin
        hs_l_d   = hs_l_q;
        vs_l_d   = vs_l_q;
        vb_l_d   = vb_l_q;
        bank_d   = bank_q;
        valid_d  = valid_q;
        wr_cnt_d = wr_cnt_q;
        if (pxl_cen) begin
            hs_l_d = HS;
            vs_l_d = VS;
            if (hs_edge) begin
                wr_cnt_d = '0;
                bank_d   = ~bank_q;
                valid_d  = 1'b1;
                vb_l_d   = VB;
            end else if (wr_cnt_q != LAST) begin
                // Over-long lines keep rewriting the last address.
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
    end

    // Buffer contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (pxl_cen) begin
            mem[{bank_q, wr_cnt_q}] <= {HB, red, green, blue};
        end
    end

    // ---------------- read side ----------------
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (pxl2_cen) begin
            if (hs_edge || rd_cnt_q == LAST) begin
                rd_cnt_d = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
    end

`ifdef JTPOPEYE_SCANLINES_EN
    // rep marks the second replay of a line; the HS resync restarts at 0.
    logic rep_q, rep_d;

    always_comb begin
        rep_d = rep_q;
        if (pxl2_cen) begin
            if (hs_edge) begin
                rep_d = 1'b0;
            end else if (rd_cnt_q == LAST) begin
                rep_d = ~rep_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    always_comb begin
        col_r = rd_word[7:5];
        col_g = rd_word[4:2];
        col_b = rd_word[1:0];
        if (!valid_q || rd_word[8]) begin
            col_r = '0;
            col_g = '0;
            col_b = '0;
        end
`ifdef JTPOPEYE_SCANLINES_EN
        else if (rep_q) begin
            col_r = rd_word[7:5] >> 1;
            col_g = rd_word[4:2] >> 1;
            col_b = rd_word[1:0] >> 1;
        end
`endif
    end

    // Output stage: one pxl2_cen behind rd_cnt, HS derived from the same
    // rd_cnt value so it stays aligned with the pixel data.
    always_comb begin
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        hb_d    = hb_q;
        vb_d    = vb_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        if (pxl2_cen) begin
            red_d   = col_r;
            green_d = col_g;
            blue_d  = col_b;
            hb_d    = rd_word[8];
            vb_d    = vb_l_q;
            hs_d    = rd_cnt_q < HS_END;
            vs_d    = vs_l_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_l_q   <= 1'b0;
            vs_l_q   <= 1'b0;
            vb_l_q   <= 1'b0;
            bank_q   <= 1'b0;
            valid_q  <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            hb_q     <= 1'b0;
            vb_q     <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            hs_l_q   <= hs_l_d;
            vs_l_q   <= vs_l_d;
            vb_l_q   <= vb_l_d;
            bank_q   <= bank_d;
            valid_q  <= valid_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            hb_q     <= hb_d;
            vb_q     <= vb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign red_2x   = red_q;
    assign green_2x = green_q;
    assign blue_2x  = blue_q;
    assign HB_2x    = hb_q;
    assign VB_2x    = vb_q;
    assign HS_2x    = hs_q;
    assign VS_2x    = vs_q;

endmodule

// File: tb/tb_jtpopeye_scan2x.sv
module tb_jtpopeye_scan2x;

    localparam int HLEN   = 320;
    localparam int HS_LEN = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl_cen = 1'b0;
    logic       pxl2_cen = 1'b0;
    logic [2:0] red = '0;
    logic [2:0] green = '0;
    logic [1:0] blue = '0;
    logic       HB = 1'b0;
    logic       VB = 1'b0;
    logic       HS = 1'b0;
    logic       VS = 1'b0;
    logic [2:0] red_2x, green_2x;
    logic [1:0] blue_2x;
    logic       HB_2x, VB_2x, HS_2x, VS_2x;
    logic [7:0] col_2x;

    assign col_2x = {red_2x, green_2x, blue_2x};

    jtpopeye_scan2x dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pxl2_cen(pxl2_cen),
        .red(red), .green(green), .blue(blue),
        .HB(HB), .VB(VB), .HS(HS), .VS(VS),
        .red_2x(red_2x), .green_2x(green_2x), .blue_2x(blue_2x),
        .HB_2x(HB_2x), .VB_2x(VB_2x), .HS_2x(HS_2x), .VS_2x(VS_2x)
    );

    always #25 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;
    bit drop_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Lines are tracked as whole objects: the line being captured, the line
    // last completed, and a playback time counted in output ticks since the
    // last resync (position = t mod HLEN, replay number = t div HLEN).
    logic [8:0] line_mem [2][HLEN];
    bit         line_ok  [2][HLEN];
    bit         wr_line;
    int         npix, t_play;
    bit         m_valid, m_vb, m_vs, m_hs_prev;
    logic [7:0] e_col;
    bit         e_hb, e_vb, e_vs, e_hs, e_hb_ok, e_col_ok;

    function automatic logic [7:0] shade(input logic [8:0] w, input bit second);
        int r, g, b;
        r = int'(w[7:5]);
        g = int'(w[4:2]);
        b = int'(w[1:0]);
`ifdef JTPOPEYE_SCANLINES_EN
        if (second) begin
            r = r / 2;
            g = g / 2;
            b = b / 2;
        end
`endif
        return 8'(r * 32 + g * 4 + b);
    endfunction

    always @(posedge clk) begin : model
        bit         edge_now, second;
        int         pos, addr;
        logic [8:0] w;
        if (!rst_n) begin
            wr_line = 0; npix = 0; t_play = 0;
            m_valid = 0; m_vb = 0; m_vs = 0; m_hs_prev = 0;
            e_col = '0; e_hb = 0; e_vb = 0; e_vs = 0; e_hs = 0;
            e_hb_ok = 1; e_col_ok = 1;
        end else begin
            edge_now = pxl_cen && HS && !m_hs_prev;
            if (pxl2_cen) begin
                pos    = t_play % HLEN;
                second = ((t_play / HLEN) % 2) == 1;
                w      = line_mem[!wr_line][pos];
                e_hb_ok  = line_ok[!wr_line][pos];
                e_col_ok = e_hb_ok || !m_valid;
                e_hb  = w[8];
                e_hs  = pos < HS_LEN;
                e_vb  = m_vb;
                e_vs  = m_vs;
                e_col = (!m_valid || w[8]) ? 8'h00 : shade(w, second);
                t_play = edge_now ? 0 : t_play + 1;
            end
            if (pxl_cen) begin
                addr = (npix < HLEN - 1) ? npix : HLEN - 1;
                line_mem[wr_line][addr] = {HB, red, green, blue};
                line_ok[wr_line][addr]  = 1;
                m_hs_prev = HS;
                m_vs = VS;
                if (edge_now) begin
                    wr_line = !wr_line;
                    npix = 0;
                    m_valid = 1;
                    m_vb = VB;
                end else begin
                    npix++;
                end
            end
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (mon_on) begin
            check("hs_2x", int'(HS_2x), int'(e_hs));
            check("vb_2x", int'(VB_2x), int'(e_vb));
            check("vs_2x", int'(VS_2x), int'(e_vs));
            if (e_hb_ok) check("hb_2x", int'(HB_2x), int'(e_hb));
            if (e_col_ok) check("colour", int'(col_2x), int'(e_col));
        end
    end

    // ---------------- stimulus ----------------
    // One input pixel = 4 clocks: pxl_cen+pxl2_cen, idle, pxl2_cen, idle.
    task automatic pix(input logic [8:0] w, input logic hs, input logic vb, input logic vs);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                {HB, red, green, blue} = w;
                HS = hs; VB = vb; VS = vs;
                pxl_cen  = 1'b1;
                pxl2_cen = !(drop_en && $urandom_range(0, 19) == 0);
            end else begin
                pxl_cen  = 1'b0;
                pxl2_cen = (i == 2);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_col"}, int'(col_2x), 0);
        check({tag, "_sync"}, int'({HB_2x, VB_2x, HS_2x, VS_2x}), 0);
    endtask

    logic [8:0] w9;
    logic [7:0] exp_dim;

    initial begin
        repeat (4) @(negedge clk);
        mon_on = 1'b1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("hs_idle", int'(HS_2x), 0);

        // Line A: word = pixel index, HS rising on its last pixel.
        for (int p = 0; p < HLEN; p++) begin
            w9 = {1'b0, 8'(p)};
            pix(w9, p == HLEN - 1, 1'b0, 1'b0);
        end
        check("a_first_col", int'(col_2x), 0);
        check("a_first_hs", int'(HS_2x), 1);

        // Line B: same content; line A is replayed meanwhile.
`ifdef JTPOPEYE_SCANLINES_EN
        exp_dim = 8'h6D;
`else
        exp_dim = 8'hFA;
`endif
        for (int q = 0; q < HLEN; q++) begin
            w9 = {1'b0, 8'(q)};
            pix(w9, q == HLEN - 1, 1'b0, 1'b0);
            if (q == 10) begin
                check("b_col22", int'(col_2x), 22);
                check("b_hs22", int'(HS_2x), 1);
            end
            if (q == 11) begin
                check("b_col24", int'(col_2x), 24);
                check("b_hs24", int'(HS_2x), 0);
            end
            if (q == 124) check("b_rep0_fa", int'(col_2x), 8'hFA);
            if (q == 284) check("b_rep1_fa", int'(col_2x), int'(exp_dim));
        end

        // Lines C and D: HB with white colour on pixels 256..319.
        for (int l = 0; l < 2; l++) begin
            for (int q = 0; q < HLEN; q++) begin
                w9 = (q >= 256) ? 9'h1FF : {1'b0, 8'(q)};
                pix(w9, q == HLEN - 1, 1'b0, 1'b1);
                if (l == 1 && q == 100) begin
                    check("d_col202", int'(col_2x), 8'hCA);
                    check("d_hb202", int'(HB_2x), 0);
                end
                if (l == 1 && q == 129) begin
                    check("d_col260", int'(col_2x), 0);
                    check("d_hb260", int'(HB_2x), 1);
                end
            end
        end

        // Random lines: varied length (short and stretched), HB/VB/VS,
        // occasional missing pxl2_cen, and one reset in mid-line.
        drop_en = 1'b1;
        for (int l = 0; l < 12; l++) begin
            int len, hbs;
            logic vbv, vsv;
            len = $urandom_range(290, 345);
            hbs = $urandom_range(240, len - 1);
            vbv = ($urandom_range(0, 3) == 0);
            vsv = ($urandom_range(0, 3) == 0);
            for (int p = 0; p < len; p++) begin
                w9 = {p >= hbs, 8'($urandom)};
                pix(w9, p >= len - 3, vbv, vsv);
                if (l == 5 && p == 150) begin
                    @(negedge clk);
                    rst_n = 1'b0;
                    #1;
                    check_zero("midreset");
                    repeat (3) @(negedge clk);
                    rst_n = 1'b1;
                end
            end
        end

        repeat (8) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
